// File: rtl/usb_pkg.sv
// Shared PID and FSM-state encodings for the USB receive sequencer.
package usb_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    OUT   = 3'd1,
    IN    = 3'd2,
    DATA0 = 3'd3,
    DATA1 = 3'd4,
    ACK   = 3'd5,
    NAK   = 3'd6,
    STALL = 3'd7
  } pid_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RCV  = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic is_data(input logic [2:0] pid);
    return (pid == DATA0) || (pid == DATA1);
  endfunction

endpackage

// File: rtl/resp_timer.sv
// 8-bit saturating response timer; tc flags the last cycle allowed for tx_done.
module resp_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds k-1 during the k-th response cycle
  assign tc = (count == TC_VAL);

endmodule

// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: classifies received packets and requests ACK/NAK handshakes.
// Optional DATA toggle checking is enabled by defining USB_RX_TOGGLE_CHK_EN.
module usb_rx_sequencer
  import usb_pkg::*;
#(
  parameter int BUF_DEPTH    = 64,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rcving,
  input  logic       r_error,
  input  logic [2:0] rx_pid,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_done,
  input  logic       host_clr,
  output logic       tx_req,
  output logic [2:0] tx_pid,
  output logic       rx_pkt_valid,
  output logic [2:0] rx_pkt_pid,
  output logic       rx_data_avail,
  output logic       rx_active,
  output logic       rx_err,
  output logic       timeout_err,
  output logic       flush_req
);

  localparam logic [6:0] BUF_LIMIT = 7'(BUF_DEPTH);

  state_e     state, state_next;
  logic       tx_req_next, valid_next, flush_next;
  logic       avail_next, rx_err_next, timeout_next;
  logic [2:0] tx_pid_next, pkt_pid_next;
  logic       eop, tc;
`ifdef USB_RX_TOGGLE_CHK_EN
  logic       toggle, toggle_next;
`endif

  assign eop = rx_active & ~rcving;

  resp_timer #(.LIMIT(RESP_TIMEOUT)) u_resp_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != RESP),
    .en  (state == RESP),
    .tc  (tc)
  );

  always_comb begin
    state_next   = state;
    tx_req_next  = 1'b0;
    valid_next   = 1'b0;
    flush_next   = 1'b0;
    tx_pid_next  = tx_pid;
    pkt_pid_next = rx_pkt_pid;
    // a set later in this block overrides the host clear
    rx_err_next  = rx_err & ~host_clr;
    timeout_next = timeout_err & ~host_clr;
    avail_next   = rx_data_avail & ~host_clr;
`ifdef USB_RX_TOGGLE_CHK_EN
    toggle_next  = toggle;
`endif
    case (state)
      IDLE: begin
        if (rcving) state_next = RCV;
        else        state_next = IDLE;
      end
      RCV: begin
        if (eop) state_next = EVAL;
        else     state_next = RCV;
      end
      EVAL: begin
        pkt_pid_next = rx_pid;
        state_next   = IDLE;
        if (r_error) begin
          rx_err_next = 1'b1;
          flush_next  = 1'b1;
        end else if (rx_pid == NONE) begin
          rx_err_next = 1'b1;
        end else if (is_data(rx_pid)) begin
          state_next  = RESP;
          tx_req_next = 1'b1;
          if (buffer_occupancy < BUF_LIMIT) begin
            tx_pid_next = ACK;
`ifdef USB_RX_TOGGLE_CHK_EN
            // a repeated DATA is still ACKed so the host advances, but its payload is dropped
            if ((rx_pid == DATA1) == toggle) begin
              valid_next  = 1'b1;
              avail_next  = 1'b1;
              toggle_next = ~toggle;
            end else begin
              flush_next = 1'b1;
            end
`else
            valid_next = 1'b1;
            avail_next = 1'b1;
`endif
          end else begin
            tx_pid_next = NAK;
            flush_next  = 1'b1;
          end
        end else begin
          valid_next = 1'b1;
        end
      end
      RESP: begin
        if (tx_done) begin
          state_next = IDLE;
        end else if (rcving) begin
          rx_err_next = 1'b1;
          state_next  = RCV;
        end else if (tc) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          tx_req_next = 1'b1;
          state_next  = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tx_req        <= 1'b0;
      tx_pid        <= 3'd0;
      rx_pkt_valid  <= 1'b0;
      rx_pkt_pid    <= 3'd0;
      rx_data_avail <= 1'b0;
      rx_active     <= 1'b0;
      rx_err        <= 1'b0;
      timeout_err   <= 1'b0;
      flush_req     <= 1'b0;
    end else begin
      state         <= state_next;
      tx_req        <= tx_req_next;
      tx_pid        <= tx_pid_next;
      rx_pkt_valid  <= valid_next;
      rx_pkt_pid    <= pkt_pid_next;
      rx_data_avail <= avail_next;
      rx_active     <= rcving;
      rx_err        <= rx_err_next;
      timeout_err   <= timeout_next;
      flush_req     <= flush_next;
    end
  end

`ifdef USB_RX_TOGGLE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle <= 1'b0;
    else     toggle <= toggle_next;
  end
`endif

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Self-checking bench: a packet-level schedule yields per-cycle expectations compared every cycle.
module tb_usb_rx_sequencer;
  import usb_pkg::*;

  localparam int N   = 16384;
  localparam int T   = 255;
  localparam int BUF = 64;

  logic       clk = 1'b0;
  logic       rst, rcving, r_error, tx_done, host_clr;
  logic [2:0] rx_pid;
  logic [6:0] buffer_occupancy;
  logic       tx_req, rx_pkt_valid, rx_data_avail, rx_active, rx_err, timeout_err, flush_req;
  logic [2:0] tx_pid, rx_pkt_pid;

  usb_rx_sequencer #(.BUF_DEPTH(BUF), .RESP_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .rcving(rcving), .r_error(r_error), .rx_pid(rx_pid),
    .buffer_occupancy(buffer_occupancy), .tx_done(tx_done), .host_clr(host_clr),
    .tx_req(tx_req), .tx_pid(tx_pid), .rx_pkt_valid(rx_pkt_valid), .rx_pkt_pid(rx_pkt_pid),
    .rx_data_avail(rx_data_avail), .rx_active(rx_active), .rx_err(rx_err),
    .timeout_err(timeout_err), .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  // stimulus per cycle
  logic       rc_a [N], er_a [N], td_a [N], hc_a [N];
  logic [2:0] pid_a [N];
  logic [6:0] occ_a [N];
  // events and expectations; index c = value just after clock edge c
  logic       v_e [N], fl_e [N], tr_e [N], re_e [N], to_e [N], av_e [N];
  logic [2:0] tp_e [N], pp_e [N];
  logic       s_re [N], s_to [N], s_av [N], pp_set [N];
  logic [2:0] pp_val [N];

  int  p, n_cyc, cur;
  bit  abort_next, junk_en, m_toggle, chk_on;
  int  n_total, n_pass;
  int  e_dir [7];

  task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // One packet plus its handshake; mode 0 = tx_done after d cycles, 1 = withheld, 2 = new packet after d cycles
  task automatic add_pkt(input int gap, input int len, input logic [2:0] pid, input logic err,
                         input logic [6:0] occ, input int mode, input int d, input bit clr_gap,
                         output int e);
    int start;
    bit resp;
    logic [2:0] rp;
    if (abort_next) begin
      start = p;
    end else begin
      for (int i = 0; i < gap; i++) begin
        if (clr_gap) hc_a[p+i] = 1'b1;
        if (junk_en) td_a[p+i] = ($urandom_range(0, 5) == 0);
      end
      start = p + gap;
    end
    abort_next = 1'b0;
    for (int i = 0; i < len; i++) rc_a[start+i] = 1'b1;
    e = start + len + 1;
    for (int c = start; c <= e; c++) begin
      pid_a[c] = pid; er_a[c] = err; occ_a[c] = occ;
      if (junk_en && c > start) td_a[c] = ($urandom_range(0, 5) == 0);
    end
    pp_set[e] = 1'b1; pp_val[e] = pid;
    resp = 1'b0; rp = ACK;
    if (err) begin
      s_re[e] = 1'b1; fl_e[e] = 1'b1;
    end else if (pid == NONE) begin
      s_re[e] = 1'b1;
    end else if (pid == DATA0 || pid == DATA1) begin
      resp = 1'b1;
      if (int'(occ) < BUF) begin
`ifdef USB_RX_TOGGLE_CHK_EN
        if ((pid == DATA1) == m_toggle) begin
          v_e[e] = 1'b1; s_av[e] = 1'b1; m_toggle = ~m_toggle;
        end else begin
          fl_e[e] = 1'b1;
        end
`else
        v_e[e] = 1'b1; s_av[e] = 1'b1;
`endif
      end else begin
        fl_e[e] = 1'b1; rp = NAK;
      end
    end else begin
      v_e[e] = 1'b1;
    end
    if (!resp) begin
      p = e + 1;
    end else if (mode == 1) begin
      for (int k = 0; k < T; k++) begin tr_e[e+k] = 1'b1; tp_e[e+k] = rp; end
      s_to[e+T] = 1'b1;
      p = e + T + 1;
    end else begin
      for (int k = 0; k < d; k++) begin tr_e[e+k] = 1'b1; tp_e[e+k] = rp; end
      if (mode == 2) begin
        s_re[e+d] = 1'b1; p = e + d; abort_next = 1'b1;
      end else begin
        td_a[e+d] = 1'b1; p = e + d + 1;
      end
    end
  endtask

  task automatic build_schedule();
    int e, rs, r, mode, d;
    logic [2:0] pid;
    logic r_er, r_a, r_t;
    logic [2:0] pp;
    for (int c = 0; c < N; c++) begin
      rc_a[c] = 1'b0; td_a[c] = 1'b0; hc_a[c] = 1'b0;
      er_a[c] = ($urandom_range(0, 3) == 0);
      pid_a[c] = 3'($urandom_range(0, 7));
      occ_a[c] = 7'($urandom_range(0, 64));
      v_e[c] = 1'b0; fl_e[c] = 1'b0; tr_e[c] = 1'b0; tp_e[c] = 3'd0;
      s_re[c] = 1'b0; s_to[c] = 1'b0; s_av[c] = 1'b0; pp_set[c] = 1'b0; pp_val[c] = 3'd0;
    end
    p = 0; abort_next = 1'b0; junk_en = 1'b0; m_toggle = 1'b0;
    add_pkt(2, 3, DATA0, 1'b0, 7'd8,  0, 3,   1'b0, e_dir[0]);
    add_pkt(1, 2, DATA0, 1'b0, 7'd8,  0, 2,   1'b0, e_dir[1]);
    add_pkt(1, 4, DATA1, 1'b0, 7'd8,  0, 1,   1'b0, e_dir[2]);
    add_pkt(1, 2, DATA1, 1'b0, 7'd64, 0, 2,   1'b0, e_dir[3]);
    add_pkt(1, 2, IN,    1'b1, 7'd8,  0, 1,   1'b0, e_dir[4]);
    hc_a[e_dir[4]+2] = 1'b1;
    add_pkt(3, 2, DATA0, 1'b0, 7'd8,  1, 0,   1'b0, e_dir[5]);
    add_pkt(2, 2, DATA1, 1'b0, 7'd8,  0, T,   1'b1, e_dir[6]);
    junk_en = 1'b1;
    rs = p;
    for (int i = 0; i < 150 && p < N - 400; i++) begin
      if ($urandom_range(0, 9) < 4) pid = ($urandom_range(0, 1) == 1) ? DATA1 : DATA0;
      else pid = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 99);
      if (r < 6)       begin mode = 1; d = 0; end
      else if (r < 20) begin mode = 2; d = $urandom_range(1, 15); end
      else if (r < 23) begin mode = 0; d = T; end
      else             begin mode = 0; d = $urandom_range(1, 12); end
      add_pkt($urandom_range(0, 3), $urandom_range(1, 6), pid, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0) ? 7'd64 : 7'($urandom_range(0, 63)), mode, d, 1'b0, e);
    end
    if (abort_next) add_pkt(0, 2, OUT, 1'b0, 7'd0, 0, 1, 1'b0, e);
    n_cyc = p + 4;
    for (int c = rs; c < n_cyc; c++) if ($urandom_range(0, 24) == 0) hc_a[c] = 1'b1;
    r_er = 1'b0; r_t = 1'b0; r_a = 1'b0; pp = 3'd0;
    for (int c = 0; c < n_cyc; c++) begin
      r_er = s_re[c] | (r_er & ~hc_a[c]);
      r_t  = s_to[c] | (r_t & ~hc_a[c]);
      r_a  = s_av[c] | (r_a & ~hc_a[c]);
      if (pp_set[c]) pp = pp_val[c];
      re_e[c] = r_er; to_e[c] = r_t; av_e[c] = r_a; pp_e[c] = pp;
    end
  endtask

  // Per-cycle comparison of every DUT output against the schedule's expectations
  always @(posedge clk) begin
    if (chk_on) begin
      #1;
      chk("rx_pkt_valid", cur, 8'(rx_pkt_valid), 8'(v_e[cur]));
      chk("flush_req", cur, 8'(flush_req), 8'(fl_e[cur]));
      chk("tx_req", cur, 8'(tx_req), 8'(tr_e[cur]));
      if (tr_e[cur]) chk("tx_pid", cur, 8'(tx_pid), 8'(tp_e[cur]));
      chk("rx_pkt_pid", cur, 8'(rx_pkt_pid), 8'(pp_e[cur]));
      chk("rx_active", cur, 8'(rx_active), 8'(rc_a[cur]));
      chk("rx_err", cur, 8'(rx_err), 8'(re_e[cur]));
      chk("timeout_err", cur, 8'(timeout_err), 8'(to_e[cur]));
      chk("rx_data_avail", cur, 8'(rx_data_avail), 8'(av_e[cur]));
    end
  end

  initial begin
    logic [2:0] pid_rst;
    n_total = 0; n_pass = 0; chk_on = 1'b0; cur = 0;
    rst = 1'b1; rcving = 1'b0; r_error = 1'b0; tx_done = 1'b0; host_clr = 1'b0;
    rx_pid = 3'd0; buffer_occupancy = 7'd0;
    build_schedule();

    // model pins: hand-derived outcomes of the directed packets
    chk("pin_p1_valid", e_dir[0], 8'(v_e[e_dir[0]]), 8'd1);
    chk("pin_p1_txreq", e_dir[0], 8'(tr_e[e_dir[0]]), 8'd1);
    chk("pin_p1_ack", e_dir[0], 8'(tp_e[e_dir[0]]), 8'(ACK));
    chk("pin_p1_drop", e_dir[0] + 3, 8'(tr_e[e_dir[0]+3]), 8'd0);
    chk("pin_p1_avail", e_dir[0], 8'(av_e[e_dir[0]]), 8'd1);
`ifdef USB_RX_TOGGLE_CHK_EN
    chk("pin_p2_valid", e_dir[1], 8'(v_e[e_dir[1]]), 8'd0);
    chk("pin_p2_flush", e_dir[1], 8'(fl_e[e_dir[1]]), 8'd1);
`else
    chk("pin_p2_valid", e_dir[1], 8'(v_e[e_dir[1]]), 8'd1);
`endif
    chk("pin_p3_valid", e_dir[2], 8'(v_e[e_dir[2]]), 8'd1);
    chk("pin_p4_flush", e_dir[3], 8'(fl_e[e_dir[3]]), 8'd1);
    chk("pin_p4_nak", e_dir[3], 8'(tp_e[e_dir[3]]), 8'(NAK));
    chk("pin_p5_err", e_dir[4], 8'(re_e[e_dir[4]]), 8'd1);
    chk("pin_p5_notx", e_dir[4], 8'(tr_e[e_dir[4]]), 8'd0);
    chk("pin_p5_clr", e_dir[4] + 2, 8'(re_e[e_dir[4]+2]), 8'd0);
    chk("pin_p6_last", e_dir[5] + T - 1, 8'(tr_e[e_dir[5]+T-1]), 8'd1);
    chk("pin_p6_to", e_dir[5] + T, 8'(to_e[e_dir[5]+T]), 8'd1);
    chk("pin_p6_drop", e_dir[5] + T, 8'(tr_e[e_dir[5]+T]), 8'd0);
    chk("pin_p7_noto", e_dir[6] + T, 8'(to_e[e_dir[6]+T]), 8'd0);

    repeat (3) @(negedge clk);
    chk("rst_tx_req", -1, 8'(tx_req), 8'd0);
    chk("rst_tx_pid", -1, 8'(tx_pid), 8'd0);
    chk("rst_valid", -1, 8'(rx_pkt_valid), 8'd0);
    chk("rst_pkt_pid", -1, 8'(rx_pkt_pid), 8'd0);
    chk("rst_avail", -1, 8'(rx_data_avail), 8'd0);
    chk("rst_active", -1, 8'(rx_active), 8'd0);
    chk("rst_rx_err", -1, 8'(rx_err), 8'd0);
    chk("rst_timeout", -1, 8'(timeout_err), 8'd0);
    chk("rst_flush", -1, 8'(flush_req), 8'd0);
    rst = 1'b0;

    for (int c = 0; c < n_cyc; c++) begin
      rcving = rc_a[c]; r_error = er_a[c]; rx_pid = pid_a[c];
      buffer_occupancy = occ_a[c]; tx_done = td_a[c]; host_clr = hc_a[c];
      cur = c; chk_on = 1'b1;
      @(negedge clk);
    end
    chk_on = 1'b0;

    // reset in the middle of a response
    pid_rst = m_toggle ? DATA1 : DATA0;
    rcving = 1'b1; r_error = 1'b0; tx_done = 1'b0; host_clr = 1'b0;
    rx_pid = pid_rst; buffer_occupancy = 7'd8;
    @(negedge clk); rcving = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5 && tx_req !== 1'b1; i++) @(negedge clk);
    chk("rst_pre_txreq", -1, 8'(tx_req), 8'd1);
    chk("rst_pre_avail", -1, 8'(rx_data_avail), 8'd1);
    @(posedge clk); #2; rst = 1'b1; #1;
    chk("async_tx_req", -1, 8'(tx_req), 8'd0);
    chk("async_avail", -1, 8'(rx_data_avail), 8'd0);
    chk("async_rx_err", -1, 8'(rx_err), 8'd0);
    chk("async_timeout", -1, 8'(timeout_err), 8'd0);
    chk("async_pkt_pid", -1, 8'(rx_pkt_pid), 8'd0);
    chk("async_tx_pid", -1, 8'(tx_pid), 8'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_tx_req", -1, 8'(tx_req), 8'd0);
    chk("post_rst_timeout", -1, 8'(timeout_err), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
